// File: rtl/mem_pkg.sv
// mem_pkg: window-decode defaults and the port-count-to-index-width helper
// shared by the interconnect and its arbiter.
package mem_pkg;
   localparam int DEV_PREFIX_BITS_DEF = 6;
   localparam int GMEM_ADDR_WIDTH_DEF = 10;
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or above ptr, wrapping.
module rr_arbiter import mem_pkg::*; #(
   parameter int NUM_PORTS = 8
) (
   input  logic [NUM_PORTS-1:0]            request,
   input  logic [idx_width(NUM_PORTS)-1:0] ptr,
   output logic [NUM_PORTS-1:0]            grant
);
   localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);
   // scan from farthest to nearest so the nearest requester wins
   always_comb begin
      grant = '0;
      for (int i = NUM_PORTS-1; i >= 0; i--)
         if (request[(int'(ptr) + i) % NUM_PORTS]) grant = ONE << ((int'(ptr) + i) % NUM_PORTS);
   end
endmodule

// File: rtl/mem_interconnect.sv
// mem_interconnect: arbitrates many cores onto one global memory port and one
// device window, returning read data one cycle after each granted read.
module mem_interconnect import mem_pkg::*; #(
   parameter int NUM_PORTS       = 8,
   parameter int ADDR_WIDTH      = 16,
   parameter int DATA_WIDTH      = 16,
   parameter int GMEM_ADDR_WIDTH = GMEM_ADDR_WIDTH_DEF,
   parameter int DEV_PREFIX_BITS = DEV_PREFIX_BITS_DEF,
   parameter int STATIC_TDM      = 0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_PORTS-1:0]                 req_valid,
   input  logic [NUM_PORTS-1:0]                 req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]      req_wdata,
   output logic [NUM_PORTS-1:0]                 req_ready,
   output logic [NUM_PORTS-1:0]                 rsp_valid,
   output logic [DATA_WIDTH-1:0]                rsp_rdata,
   output logic [GMEM_ADDR_WIDTH-1:0]           gmem_addr,
   output logic                                 gmem_we,
   output logic [DATA_WIDTH-1:0]                gmem_wdata,
   input  logic [DATA_WIDTH-1:0]                gmem_q,
   output logic [idx_width(NUM_PORTS)-1:0]      device_core_id,
   output logic                                 device_write_en,
   output logic                                 device_read_en,
   output logic [ADDR_WIDTH-DEV_PREFIX_BITS-1:0] device_addr,
   output logic [DATA_WIDTH-1:0]                device_data_out,
   input  logic [DATA_WIDTH-1:0]                device_data_in
);
   localparam int IW = idx_width(NUM_PORTS);
   logic [IW-1:0]         r_ptr, w_idx;
   logic [NUM_PORTS-1:0]  r_slot, r_rsp_valid, w_req, w_rr_grant, w_grant;
   logic                  r_dev_sel, w_any, w_write, w_dev;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   // masking requests during reset keeps every enable low and suppresses responses
   assign w_req = reset ? '0 : req_valid;
   rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (.request(w_req), .ptr(r_ptr), .grant(w_rr_grant));
   assign w_grant = (STATIC_TDM != 0) ? (r_slot & w_req) : w_rr_grant;
   assign w_any   = |w_grant;
   always_comb begin
      w_idx = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         if (w_grant[i]) w_idx = IW'(i);
   end
   assign w_addr  = req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_wdata = req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
   assign w_write = req_write[w_idx];
   assign w_dev   = &w_addr[ADDR_WIDTH-1 -: DEV_PREFIX_BITS];
   assign req_ready       = w_grant;
   assign gmem_addr       = w_addr[GMEM_ADDR_WIDTH-1:0];
   assign gmem_we         = w_any & w_write & ~w_dev;
   assign gmem_wdata      = w_wdata;
   assign device_core_id  = w_idx;
   assign device_write_en = w_any & w_write & w_dev;
   assign device_read_en  = w_any & ~w_write & w_dev;
   assign device_addr     = w_addr[ADDR_WIDTH-DEV_PREFIX_BITS-1:0];
   assign device_data_out = w_wdata;
   assign rsp_valid       = r_rsp_valid;
   assign rsp_rdata       = r_dev_sel ? device_data_in : gmem_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr       <= '0;
         r_slot      <= NUM_PORTS'(1);
         r_rsp_valid <= '0;
         r_dev_sel   <= 1'b0;
      end else begin
         r_slot      <= {r_slot[NUM_PORTS-2:0], r_slot[NUM_PORTS-1]};
         if (w_any) r_ptr <= (w_idx == IW'(NUM_PORTS-1)) ? '0 : w_idx + 1'b1;
         r_rsp_valid <= w_write ? '0 : w_grant;
         r_dev_sel   <= w_any & ~w_write & w_dev;
      end
   end
endmodule
